// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius (Simon) game sequencer.
package genius_pkg;

   localparam int unsigned COLOR_W   = 2;
   localparam int unsigned DEFAULT_N = 4;

   typedef enum logic [2:0] {
      StIdle,
      StShowOn,
      StShowOff,
      StInput,
      StWin,
      StLose
   } state_e;

   // Colour index to one-hot LED/button pattern.
   function automatic logic [3:0] color_onehot(input logic [COLOR_W-1:0] color);
      logic [3:0] oh;
      oh        = 4'b0000;
      oh[color] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/genius_step_counter.sv
// N-bit step counter with clear/enable and terminal-count compare against a limit.
module genius_step_counter #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             r_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Width-1:0] limit_i,
   output logic [Width-1:0] count_o,
   output logic             tc_o
);

   logic [Width-1:0] count_q, count_d;

   // Next count: clear has priority over increment.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + Width'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge r_i) begin
      if (r_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == limit_i);

endmodule

// File: rtl/genius_ctrl.sv
// Genius game sequencer: plays back the stored colour sequence, then checks presses.
module genius_ctrl
   import genius_pkg::*;
#(
   parameter int unsigned N          = DEFAULT_N,
   parameter int unsigned SHOW_TICKS = 2,
   parameter int unsigned GAP_TICKS  = 1
) (
   input  logic               clk_i,
   input  logic               r_i,
   input  logic               start_i,
   input  logic               tick_i,
   input  logic [3:0]         btn_i,
   input  logic [COLOR_W-1:0] seq_color_i,
   output logic [N-1:0]       seq_addr_o,
   output logic [3:0]         led_o,
   output logic [N-1:0]       round_o,
   output logic               busy_o,
   output logic               win_o,
   output logic               lose_o
);

   localparam int unsigned MaxTicks = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
   localparam int unsigned DwellW   = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
   localparam logic [DwellW-1:0] ShowLast = DwellW'(SHOW_TICKS - 1);
   localparam logic [DwellW-1:0] GapLast  = DwellW'(GAP_TICKS - 1);
   localparam logic [N-1:0]      RoundMax = {N{1'b1}};

   state_e            state_q, state_d;
   logic [N-1:0]      round_q, round_d;
   logic [DwellW-1:0] dwell_q, dwell_d;
   logic [N-1:0]      step;
   logic              step_tc;
   logic              step_clr;
   logic              step_en;
   logic              btn_ok;

   // Step index tracks the current sequence position; tc marks the last step of the round.
   genius_step_counter #(
      .Width (N)
   ) u_step (
      .clk_i   (clk_i),
      .r_i     (r_i),
      .clr_i   (step_clr),
      .en_i    (step_en),
      .limit_i (round_q),
      .count_o (step),
      .tc_o    (step_tc)
   );

   // A multi-bit press never equals a one-hot pattern, so it falls into the mismatch path.
   assign btn_ok = (btn_i == color_onehot(seq_color_i));

   // Next-state logic for state, round, dwell and step control.
   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      dwell_d  = dwell_q;
      step_clr = 1'b0;
      step_en  = 1'b0;
      unique case (state_q)
         StIdle, StWin, StLose: begin
            // tick_i is not counted here, so a coincident start still gets a full dwell.
            if (start_i) begin
               state_d  = StShowOn;
               round_d  = '0;
               dwell_d  = '0;
               step_clr = 1'b1;
            end
         end
         StShowOn: begin
            if (tick_i) begin
               if (dwell_q == ShowLast) begin
                  dwell_d = '0;
                  state_d = StShowOff;
               end else begin
                  dwell_d = dwell_q + DwellW'(1);
               end
            end
         end
         StShowOff: begin
            if (tick_i) begin
               if (dwell_q == GapLast) begin
                  dwell_d = '0;
                  if (step_tc) begin
                     step_clr = 1'b1;
                     state_d  = StInput;
                  end else begin
                     step_en = 1'b1;
                     state_d = StShowOn;
                  end
               end else begin
                  dwell_d = dwell_q + DwellW'(1);
               end
            end
         end
         StInput: begin
            if (btn_i != 4'b0000) begin
               if (!btn_ok) begin
                  state_d = StLose;
               end else if (!step_tc) begin
                  step_en = 1'b1;
               end else if (round_q == RoundMax) begin
                  state_d = StWin;
               end else begin
                  round_d  = round_q + N'(1);
                  step_clr = 1'b1;
                  dwell_d  = '0;
                  state_d  = StShowOn;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, round and dwell registers.
   always_ff @(posedge clk_i or posedge r_i) begin
      if (r_i) begin
         state_q <= StIdle;
         round_q <= '0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         dwell_q <= dwell_d;
      end
   end

   // Moore outputs decoded from registered state, step and round.
   always_comb begin
      seq_addr_o = '0;
      led_o      = 4'b0000;
      busy_o     = 1'b0;
      win_o      = 1'b0;
      lose_o     = 1'b0;
      round_o    = round_q;
      unique case (state_q)
         StShowOn: begin
            seq_addr_o = step;
            led_o      = color_onehot(seq_color_i);
            busy_o     = 1'b1;
         end
         StShowOff: begin
            busy_o = 1'b1;
         end
         StInput: begin
            seq_addr_o = step;
            busy_o     = 1'b1;
         end
         StWin: begin
            win_o = 1'b1;
         end
         StLose: begin
            lose_o = 1'b1;
         end
         default: begin
            seq_addr_o = '0;
         end
      endcase
   end

endmodule

// File: doc/genius_ctrl.md
# genius_ctrl

Game sequencer for the Genius (Simon) memory game. It drives the shared colour-sequence store: it steps through the stored sequence to flash LEDs, then checks the player's button presses against the same sequence, growing the round by one step per success. It sits between the slow timebase tick, the sequence ROM, the button synchronisers and the LED/score display logic.

## Interface
- N, 4: address/round width; max rounds = 2^N (16)
- SHOW_TICKS, 2: tick_i pulses each colour is lit during playback (≥1)
- GAP_TICKS, 1: tick_i pulses LEDs are dark between playback colours (≥1)

- clk_i  in  1  system clock
- r_i  in  1  reset, asynchronous, active-high
- start_i  in  1  single-cycle start/restart pulse
- tick_i  in  1  single-cycle timebase pulse (playback pacing)
- btn_i  in  4  button press pulses, one-hot, one cycle per press; 0000 = no press
- seq_color_i  in  2  colour index at seq_addr_o, combinational from ROM, valid same cycle
- seq_addr_o  out  N  sequence step being shown/checked
- led_o  out  4  one-hot LED drive
- round_o  out  N  current round index r (round has r+1 steps)
- busy_o  out  1  high in SHOW_ON, SHOW_OFF, INPUT
- win_o  out  1  held high in WIN
- lose_o  out  1  held high in LOSE

## Operation
- States: IDLE, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE. Registers: state, round (N), step (N), dwell (dwell counter).
- IDLE: all outputs 0. start_i → round=0, step=0, dwell=0, SHOW_ON.
- SHOW_ON: seq_addr_o=step, led_o=onehot(seq_color_i). Each tick_i increments dwell; tick_i with dwell==SHOW_TICKS-1 → dwell=0, SHOW_OFF.
- SHOW_OFF: led_o=0. tick_i with dwell==GAP_TICKS-1 → dwell=0; if step==round: step=0, INPUT; else step+1, SHOW_ON.
- INPUT: seq_addr_o=step, led_o=0, tick_i ignored, no timeout. On btn_i≠0:
  - btn_i==onehot(seq_color_i) and step<round → step+1.
  - match and step==round and round==2^N-1 → WIN.
  - match and step==round otherwise → round+1, step=0, dwell=0, SHOW_ON.
  - mismatch or more than one bit set → LOSE.
- WIN/LOSE: flag held, led_o=0, round_o frozen at final value. start_i → same as start from IDLE.
- start_i ignored while busy_o=1. btn_i ignored outside INPUT.
- Colour encoding: 0→0001, 1→0010, 2→0100, 3→1000.
- round and step never wrap: max value 2^N-1 handled by WIN path.

## Timing
- Reset (async, any state, mid-round included): state=IDLE, round=step=dwell=0, all outputs 0.
- Moore outputs from registered state/step/round. led_o/seq_addr_o change one cycle after the edge that samples the trigger (start_i, tick_i, btn_i).
- btn_i sampled on the edge it is high; one press evaluated per cycle.
- Playback length of round r: (r+1)·(SHOW_TICKS+GAP_TICKS) ticks.
- Final press → win_o/lose_o high on the next cycle.
- tick_i and btn_i together in INPUT: btn_i evaluated, tick_i dropped. start_i and tick_i together in IDLE: start wins, tick is not counted.

## Structure
- Shared package genius_pkg: state enum, COLOR_W=2, colour→one-hot function, default N.
- One sub-module: genius_step_counter (N-bit counter: clear, enable, limit input, combinational tc_o = count==limit). Used for step vs round; dwell stays inline.

## Test plan
- Reset, then start_i, ROM = {0,…}, SHOW_TICKS=2, GAP_TICKS=1 → led_o=0001 for 2 ticks, 0000 for 1 tick, then INPUT with busy_o=1.
- Round 0 press 0001 → round_o=1, playback of steps 0,1. Round 1 press correct colour then wrong → lose_o=1 one cycle after the wrong press.
- Press 0011 (two bits) in INPUT → LOSE.
- Correct play through all 16 rounds → win_o=1, round_o=15, busy_o=0.
- Assert r_i mid-SHOW_ON of round 3 → outputs 0 immediately, IDLE; start_i restarts at round 0.
- From LOSE, start_i → lose_o=0, round_o=0, SHOW_ON. start_i during INPUT → no effect.
